stage_writeback_pipe: RTL and testbench

//  Parametrised memory/writeback stage for the vector ASIP, successor to the fixed 1-cycle writeback.

---
 rtl/stage_writeback_pipe_if.sv | 36 +++
 rtl/stage_writeback_pipe.sv | 80 ++++++++
 tb/tb_stage_writeback_pipe.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_writeback_pipe_if.sv
// Handshake bundle between execute, the memory/writeback stage and the regfile write port.
// The master side issues ops and consumes writebacks; the slave side is the stage itself.
interface stage_writeback_pipe_if #(
    parameter int VEC_SIZE = 4,
    parameter int REG_SIZE = 8,
    parameter int ADDR_W   = 8,
    parameter int RD_W     = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         mem_we;
    logic [VEC_SIZE-1:0]          lane_mask;
    logic [1:0]                   wb_sel;
    logic [ADDR_W-1:0]            address;
    logic [REG_SIZE-1:0]          imm;
    logic [VEC_SIZE*REG_SIZE-1:0] write_data;
    logic [VEC_SIZE*REG_SIZE-1:0] alu_result;
    logic [RD_W-1:0]              rd;
    logic                         wb_valid;
    logic                         out_ready;
    logic                         wb_we;
    logic [RD_W-1:0]              wb_rd;
    logic [VEC_SIZE*REG_SIZE-1:0] wb_data;

    modport master (
        output in_valid, mem_we, lane_mask, wb_sel, address, imm,
               write_data, alu_result, rd, out_ready,
        input  in_ready, wb_valid, wb_we, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, mem_we, lane_mask, wb_sel, address, imm,
               write_data, alu_result, rd, out_ready,
        output in_ready, wb_valid, wb_we, wb_rd, wb_data
    );
endinterface

// File: rtl/stage_writeback_pipe.sv
// Memory/writeback stage for the vector ASIP: lane-masked stores, synchronous loads and
// regfile writeback delivered LAT cycles after acceptance, with valid/ready back-pressure.
module stage_writeback_pipe #(
    parameter int VEC_SIZE = 4,
    parameter int REG_SIZE = 8,
    parameter int ADDR_W   = 8,
    parameter int LAT      = 2,
    parameter int RD_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    stage_writeback_pipe_if.slave bus
);
    localparam int W     = VEC_SIZE * REG_SIZE;
    localparam int DEPTH = 1 << ADDR_W;

    logic [W-1:0]    r_mem   [DEPTH];
    logic            r_valid [LAT];
    logic            r_we    [LAT];
    logic [RD_W-1:0] r_rd    [LAT];
    logic [W-1:0]    r_data  [LAT];

    logic         w_adv;
    logic         w_accept;
    logic [W-1:0] w_result;

    // The whole pipe freezes only when the output holds an op nobody is taking.
    assign w_adv    = !(r_valid[LAT-1] && !bus.out_ready);
    assign w_accept = bus.in_valid && w_adv;

    assign bus.in_ready = w_adv;
    assign bus.wb_valid = r_valid[LAT-1];
    assign bus.wb_we    = r_we[LAT-1];
    assign bus.wb_rd    = r_rd[LAT-1];
    assign bus.wb_data  = r_data[LAT-1];

    always_comb begin
        w_result = '0;
        case (bus.wb_sel)
            2'd0:    w_result = r_mem[bus.address];
            2'd1:    w_result = bus.alu_result;
            2'd2:    w_result = {VEC_SIZE{bus.imm}};
            default: w_result = '0;
        endcase
    end

    // Memory is not reset; the read above sees the pre-store word, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (w_accept && bus.mem_we) begin
            for (int i = 0; i < VEC_SIZE; i++) begin
                if (bus.lane_mask[i]) begin
                    r_mem[bus.address][i*REG_SIZE +: REG_SIZE] <= bus.write_data[i*REG_SIZE +: REG_SIZE];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LAT; k++) begin
                r_valid[k] <= 1'b0;
                r_we[k]    <= 1'b0;
                r_rd[k]    <= '0;
                r_data[k]  <= '0;
            end
        end else if (w_adv) begin
            for (int k = LAT - 1; k > 0; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_we[k]    <= r_we[k-1];
                r_rd[k]    <= r_rd[k-1];
                r_data[k]  <= r_data[k-1];
            end
            // Bubbles carry zeroed payload so idle outputs read as 0.
            r_valid[0] <= w_accept;
            r_we[0]    <= w_accept && (bus.wb_sel != 2'd3);
            r_rd[0]    <= w_accept ? bus.rd : '0;
            r_data[0]  <= w_accept ? w_result : '0;
        end
    end
endmodule

// File: tb/tb_stage_writeback_pipe.sv
// Scoreboard bench for stage_writeback_pipe: a driver feeds a reference memory model and
// an expectation queue, an independent monitor checks every op the stage presents.
module tb_stage_writeback_pipe;
    localparam int VEC_SIZE = 4;
    localparam int REG_SIZE = 8;
    localparam int ADDR_W   = 8;
    localparam int LAT      = 2;
    localparam int RD_W     = 4;
    localparam int W        = VEC_SIZE * REG_SIZE;
    localparam int DEPTH    = 1 << ADDR_W;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic [VEC_SIZE-1:0] mask;
        logic [1:0]          sel;
        logic [ADDR_W-1:0]   addr;
        logic [REG_SIZE-1:0] imm;
        logic [W-1:0]        wd;
        logic [W-1:0]        alu;
        logic [RD_W-1:0]     rd;
    } op_t;

    typedef struct {
        logic            we;
        logic [RD_W-1:0] rd;
        logic [W-1:0]    data;
        int              advAt;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stage_writeback_pipe_if #(
        .VEC_SIZE(VEC_SIZE), .REG_SIZE(REG_SIZE), .ADDR_W(ADDR_W), .RD_W(RD_W)
    ) bus ();

    stage_writeback_pipe #(
        .VEC_SIZE(VEC_SIZE), .REG_SIZE(REG_SIZE), .ADDR_W(ADDR_W), .LAT(LAT), .RD_W(RD_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    logic [W-1:0] refMem [DEPTH];
    exp_t         expQ[$];
    int           checks    = 0;
    int           errors    = 0;
    int           advCount  = 0;
    bit           monEnable = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic op_t mkOp(input logic we, input logic [VEC_SIZE-1:0] mask, input logic [1:0] sel,
                                 input logic [ADDR_W-1:0] addr, input logic [REG_SIZE-1:0] imm,
                                 input logic [W-1:0] wd, input logic [W-1:0] alu, input logic [RD_W-1:0] rd);
        op_t o;
        o.valid = 1'b1; o.we = we; o.mask = mask; o.sel = sel; o.addr = addr;
        o.imm = imm; o.wd = wd; o.alu = alu; o.rd = rd;
        return o;
    endfunction

    // Reference behaviour: the writeback value is decided from the memory as it was before this op.
    function automatic logic [W-1:0] refResult(input op_t o);
        case (o.sel)
            2'd0:    return refMem[o.addr];
            2'd1:    return o.alu;
            2'd2:    return {VEC_SIZE{o.imm}};
            default: return '0;
        endcase
    endfunction

    task automatic refStore(input op_t o);
        for (int i = 0; i < VEC_SIZE; i++)
            if (o.mask[i]) refMem[o.addr][i*REG_SIZE +: REG_SIZE] = o.wd[i*REG_SIZE +: REG_SIZE];
    endtask

    task automatic applyStimulus(input op_t o, input bit outRdy, output bit accepted);
        exp_t e;
        @(negedge clk);
        bus.in_valid   = o.valid;
        bus.mem_we     = o.we;
        bus.lane_mask  = o.mask;
        bus.wb_sel     = o.sel;
        bus.address    = o.addr;
        bus.imm        = o.imm;
        bus.write_data = o.wd;
        bus.alu_result = o.alu;
        bus.rd         = o.rd;
        bus.out_ready  = outRdy;
        #1;
        accepted = o.valid && bus.in_ready;
        if (accepted) begin
            e.we    = (o.sel != 2'd3);
            e.rd    = o.rd;
            e.data  = refResult(o);
            e.advAt = advCount;
            expQ.push_back(e);
            if (o.we) refStore(o);
        end
    endtask

    task automatic sendOp(input op_t o);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) applyStimulus(o, 1'b1, acc);
        if (!acc) checkOutput("sendTimeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int n);
        op_t z;
        bit  acc;
        z = '0;
        repeat (n) applyStimulus(z, 1'b1, acc);
    endtask

    // Monitor: samples after the driver has settled inputs, pops an expectation per consumed op.
    initial begin
        exp_t            e;
        bit              prevStalled;
        logic [W-1:0]    prevData;
        logic [RD_W-1:0] prevRd;
        prevStalled = 1'b0;
        prevData    = '0;
        prevRd      = '0;
        forever begin
            @(negedge clk);
            #3;
            if (monEnable) begin
                checkOutput("inReady", 64'(bus.in_ready), 64'(!(bus.wb_valid && !bus.out_ready)));
                if (prevStalled) begin
                    checkOutput("holdValid", 64'(bus.wb_valid), 64'(1));
                    checkOutput("holdRd", 64'(bus.wb_rd), 64'(prevRd));
                    checkOutput("holdData", 64'(bus.wb_data), 64'(prevData));
                end
                if (bus.wb_valid) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedOp", 64'(1), 64'(0));
                    end else begin
                        e = expQ[0];
                        checkOutput("wbWe", 64'(bus.wb_we), 64'(e.we));
                        checkOutput("wbRd", 64'(bus.wb_rd), 64'(e.rd));
                        checkOutput("wbData", 64'(bus.wb_data), 64'(e.data));
                        if (!prevStalled) checkOutput("latency", 64'(advCount), 64'(e.advAt + LAT));
                        if (bus.out_ready) void'(expQ.pop_front());
                    end
                end else begin
                    checkOutput("bubbleWe", 64'(bus.wb_we), 64'(0));
                    checkOutput("bubbleRd", 64'(bus.wb_rd), 64'(0));
                    checkOutput("bubbleData", 64'(bus.wb_data), 64'(0));
                end
                prevStalled = bus.wb_valid && !bus.out_ready;
                prevData    = bus.wb_data;
                prevRd      = bus.wb_rd;
            end else begin
                prevStalled = 1'b0;
            end
            if (!bus.wb_valid || bus.out_ready) advCount++;
        end
    end

    initial begin
        op_t opA, opB, opX;
        bit  acc;

        bus.in_valid = 1'b0; bus.mem_we = 1'b0; bus.lane_mask = '0; bus.wb_sel = '0;
        bus.address = '0; bus.imm = '0; bus.write_data = '0; bus.alu_result = '0;
        bus.rd = '0; bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("resetValid", 64'(bus.wb_valid), 64'(0));
        checkOutput("resetWe", 64'(bus.wb_we), 64'(0));
        checkOutput("resetData", 64'(bus.wb_data), 64'(0));
        reset = 1'b1;
        #1;
        checkOutput("resetInReady", 64'(bus.in_ready), 64'(1));
        monEnable = 1'b1;

        // Give every memory word a known value so random loads have a defined answer.
        for (int a = 0; a < DEPTH; a++)
            sendOp(mkOp(1'b1, '1, 2'd3, ADDR_W'(a), '0, W'($urandom), '0, RD_W'(a)));
        idle(LAT + 1);

        $display("[TB] alu writeback");
        sendOp(mkOp(1'b0, '0, 2'd1, '0, '0, '0, 32'h04030201, 4'd5));
        idle(LAT + 1);

        $display("[TB] lane-masked store then load");
        sendOp(mkOp(1'b1, '1, 2'd3, 8'h10, '0, 32'h11223344, '0, 4'd0));
        sendOp(mkOp(1'b1, 4'b0101, 2'd3, 8'h10, '0, 32'hAABBCCDD, '0, 4'd0));
        sendOp(mkOp(1'b0, '0, 2'd0, 8'h10, '0, '0, '0, 4'd7));
        idle(LAT + 1);

        $display("[TB] immediate broadcast and no-write op");
        sendOp(mkOp(1'b0, '0, 2'd2, '0, 8'h7F, '0, '0, 4'd3));
        sendOp(mkOp(1'b0, '0, 2'd3, '0, 8'h12, '0, 32'hDEADBEEF, 4'd9));
        idle(LAT + 1);

        $display("[TB] output stall with back-to-back ops");
        sendOp(mkOp(1'b0, '0, 2'd1, '0, '0, '0, 32'hA0A0A0A0, 4'd1));
        sendOp(mkOp(1'b1, '1, 2'd1, 8'h41, '0, 32'h5566_7788, 32'hB0B0B0B0, 4'd2));
        opX = mkOp(1'b1, '1, 2'd1, 8'h40, '0, 32'hFEEDFACE, 32'hC1C1C1C1, 4'd4);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(opX, 1'b0, acc);
            checkOutput("stallAccept", 64'(acc), 64'(0));
        end
        sendOp(mkOp(1'b0, '0, 2'd1, '0, '0, '0, 32'hC0C0C0C0, 4'd3));
        sendOp(mkOp(1'b0, '0, 2'd0, 8'h40, '0, '0, '0, 4'd6));
        idle(LAT + 1);

        $display("[TB] top address and read-first store+load");
        sendOp(mkOp(1'b1, '1, 2'd3, 8'hFF, '0, 32'h0BADF00D, '0, 4'd0));
        sendOp(mkOp(1'b0, '0, 2'd0, 8'hFF, '0, '0, '0, 4'd8));
        sendOp(mkOp(1'b1, '1, 2'd0, 8'h30, '0, 32'h13579BDF, '0, 4'd10));
        sendOp(mkOp(1'b0, '0, 2'd0, 8'h30, '0, '0, '0, 4'd11));
        idle(LAT + 1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            opX = mkOp(1'($urandom), VEC_SIZE'($urandom), 2'($urandom), ADDR_W'($urandom),
                       REG_SIZE'($urandom), W'($urandom), W'($urandom), RD_W'($urandom));
            opX.valid = ($urandom_range(0, 3) != 0);
            applyStimulus(opX, ($urandom_range(0, 3) != 0), acc);
        end
        idle(LAT + 2);
        checkOutput("drainEmpty", 64'(expQ.size()), 64'(0));

        $display("[TB] reset mid-traffic");
        opA = mkOp(1'b1, '1, 2'd1, 8'h20, '0, 32'h2468ACE0, 32'h99887766, 4'd12);
        opB = mkOp(1'b1, '1, 2'd2, 8'h21, 8'h5A, 32'h1357_2468, '0, 4'd13);
        sendOp(opA);
        sendOp(opB);
        idle(1);
        #1;
        monEnable = 1'b0;
        checkOutput("preResetValid", 64'(bus.wb_valid), 64'(1));
        reset = 1'b0;
        #1;
        checkOutput("asyncValid", 64'(bus.wb_valid), 64'(0));
        checkOutput("asyncWe", 64'(bus.wb_we), 64'(0));
        checkOutput("asyncData", 64'(bus.wb_data), 64'(0));
        expQ.delete();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("releaseInReady", 64'(bus.in_ready), 64'(1));
        monEnable = 1'b1;
        sendOp(mkOp(1'b0, '0, 2'd0, 8'h20, '0, '0, '0, 4'd14));
        sendOp(mkOp(1'b0, '0, 2'd0, 8'h21, '0, '0, '0, 4'd15));
        idle(LAT + 2);
        checkOutput("finalEmpty", 64'(expQ.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
